syncfifo_param: RTL

SYNCFIFO_PARAM -- requirements
Module: syncfifo_param

---
 rtl/syncfifo_pkg.sv | 20 ++
 rtl/syncfifo_param_if.sv | 37 +++
 rtl/syncfifo_mem.sv | 25 ++
 rtl/syncfifo_param.sv | 117 +++++++++++
 4 files changed

// File: rtl/syncfifo_pkg.sv
// Shared constants and types for the parameterised synchronous FIFO.
package syncfifo_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 16;
  localparam int unsigned FWFT_DEF   = 0;

  localparam int unsigned ERR_OVF_BIT = 0;
  localparam int unsigned ERR_UDF_BIT = 1;

  typedef enum logic {
    REG_READ = 1'b0,
    FWFT     = 1'b1
  } fifoMode_e;

  function automatic fifoMode_e modeFromParam(input int unsigned fwft);
    return (fwft != 0) ? FWFT : REG_READ;
  endfunction

endpackage

// File: rtl/syncfifo_param_if.sv
// Request/response bundle between a FIFO user (master) and the FIFO itself (slave).
interface syncfifo_param_if #(
  parameter int unsigned DATA_W = syncfifo_pkg::DATA_W_DEF,
  parameter int unsigned DEPTH  = syncfifo_pkg::DEPTH_DEF
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic              wrEn_i;
  logic [DATA_W-1:0] wdata_i;
  logic              rdEn_i;
  logic [DATA_W-1:0] rdata_o;
  logic              flush_i;
  logic [AW:0]       afThr_i;
  logic [AW:0]       aeThr_i;
  logic              full_o;
  logic              empty_o;
  logic              almFull_o;
  logic              almEmpty_o;
  logic [AW:0]       count_o;
  logic              overflw_o;
  logic              underflw_o;
  logic [1:0]        errSticky_o;
  logic              clrErr_i;

  modport master (
    output wrEn_i, wdata_i, rdEn_i, flush_i, afThr_i, aeThr_i, clrErr_i,
    input  rdata_o, full_o, empty_o, almFull_o, almEmpty_o, count_o,
    input  overflw_o, underflw_o, errSticky_o
  );

  modport slave (
    input  wrEn_i, wdata_i, rdEn_i, flush_i, afThr_i, aeThr_i, clrErr_i,
    output rdata_o, full_o, empty_o, almFull_o, almEmpty_o, count_o,
    output overflw_o, underflw_o, errSticky_o
  );

endinterface

// File: rtl/syncfifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, not reset.
module syncfifo_mem #(
  parameter int unsigned DATA_W = syncfifo_pkg::DATA_W_DEF,
  parameter int unsigned DEPTH  = syncfifo_pkg::DEPTH_DEF,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wrEn_i,
  input  logic [AW-1:0]     wrAddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     rdAddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn_i) begin
      mem_q[wrAddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rdAddr_i];

endmodule

// File: rtl/syncfifo_param.sv
// Single-clock FIFO with registered-read or first-word-fall-through output,
// programmable almost-full/empty flags, and pulsed plus sticky error reporting.
module syncfifo_param #(
  parameter int unsigned DATA_W = syncfifo_pkg::DATA_W_DEF,
  parameter int unsigned DEPTH  = syncfifo_pkg::DEPTH_DEF,
  parameter int unsigned FWFT   = syncfifo_pkg::FWFT_DEF
) (
  input logic           clk,
  input logic           rst,
  syncfifo_param_if.slave bus
);
  import syncfifo_pkg::*;

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned PtrW = AW + 1;
  localparam fifoMode_e   Mode = modeFromParam(FWFT);

  logic [AW:0]       wrPtr_q, wrPtr_d;
  logic [AW:0]       rdPtr_q, rdPtr_d;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] memRdata;
  logic [1:0]        errSticky_q, errSticky_d;
  logic              ovf_q, udf_q;
  logic              full, empty;
  logic              wrAcc, rdAcc, ovfHit, udfHit;

  // Flags come from registered count only, never from this cycle's requests.
  assign full  = (count_q == PtrW'(DEPTH));
  assign empty = (count_q == '0);

  assign wrAcc  = bus.wrEn_i & ~full  & ~bus.flush_i;
  assign rdAcc  = bus.rdEn_i & ~empty & ~bus.flush_i;
  assign ovfHit = bus.wrEn_i &  full  & ~bus.flush_i;
  assign udfHit = bus.rdEn_i &  empty & ~bus.flush_i;

  syncfifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk      (clk),
    .wrEn_i   (wrAcc),
    .wrAddr_i (wrPtr_q[AW-1:0]),
    .wdata_i  (bus.wdata_i),
    .rdAddr_i (rdPtr_q[AW-1:0]),
    .rdata_o  (memRdata)
  );

  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    rdata_d     = rdata_q;
    errSticky_d = errSticky_q;

    if (bus.clrErr_i) begin
      errSticky_d = '0;
    end
    // Setting after clearing lets a coincident error win over the clear.
    if (ovfHit) begin
      errSticky_d[ERR_OVF_BIT] = 1'b1;
    end
    if (udfHit) begin
      errSticky_d[ERR_UDF_BIT] = 1'b1;
    end

    if (bus.flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
    end else begin
      if (wrAcc) begin
        wrPtr_d = wrPtr_q + 1'b1;
      end
      if (rdAcc) begin
        rdPtr_d = rdPtr_q + 1'b1;
      end
    end

    if ((Mode == REG_READ) && rdAcc) begin
      rdata_d = memRdata;
    end

    count_d = wrPtr_d - rdPtr_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      rdata_q     <= '0;
      errSticky_q <= '0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      rdata_q     <= rdata_d;
      errSticky_q <= errSticky_d;
      ovf_q       <= ovfHit;
      udf_q       <= udfHit;
    end
  end

  // Fall-through output is masked while empty so stale entries never leak out.
  assign bus.rdata_o     = (Mode == REG_READ) ? rdata_q : (empty ? '0 : memRdata);
  assign bus.full_o      = full;
  assign bus.empty_o     = empty;
  assign bus.count_o     = count_q;
  assign bus.almFull_o   = (count_q >= bus.afThr_i);
  assign bus.almEmpty_o  = (count_q <= bus.aeThr_i);
  assign bus.overflw_o   = ovf_q;
  assign bus.underflw_o  = udf_q;
  assign bus.errSticky_o = errSticky_q;

endmodule
